rf_exec_ctrl: RTL and testbench

// - Initiator side of the 8x8 register-file port set: accepts one instruction
//   per valid/ready handshake and sequences its register-file transaction.
// - Drives the two read addresses, captures operands, computes an 8-bit result
//   and performs one write-back. Sits between the instruction source and the

---
 rtl/rf_exec_ctrl_pkg.sv | 33 +++
 rtl/rf_exec_ctrl_alu.sv | 36 +++
 rtl/rf_exec_ctrl.sv | 146 ++++++++++++++
 tb/tb_rf_exec_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_exec_ctrl_pkg.sv
// ============================================================================
// Module : rf_exec_ctrl_pkg
// Brief  : Shared opcodes, state encodings and width defaults for rf_exec_ctrl
// Rev    : 1.0
// ============================================================================
`default_nettype none

package rf_exec_ctrl_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDI = 3'b101;
  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  function automatic logic op_writes(input logic [2:0] op);
    return op != OP_NOP;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rf_exec_ctrl_alu.sv
// ============================================================================
// Module : rf_exec_ctrl_alu
// Brief  : Combinational ALU; all arithmetic wraps mod 2**DATA_W
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rf_exec_ctrl_alu
  import rf_exec_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_LDI:  y = imm;
      OP_MOV:  y = a;
      default: y = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/rf_exec_ctrl.sv
// ============================================================================
// Module : rf_exec_ctrl
// Brief  : Register-file initiator: accept, read, execute, write back
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rf_exec_ctrl
  import rf_exec_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [ADDR_W-1:0] instr_rs1,
  input  logic [ADDR_W-1:0] instr_rs2,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [ADDR_W-1:0] rf_read_addr1,
  output logic [ADDR_W-1:0] rf_read_addr2,
  input  logic [DATA_W-1:0] rf_read_data1,
  input  logic [DATA_W-1:0] rf_read_data2,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_write_enable,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  logic [1:0]        state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [ADDR_W-1:0] rs1_q, rs1_d;
  logic [ADDR_W-1:0] rs2_q, rs2_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q, zero_d;
  logic [DATA_W-1:0] alu_y;

  rf_exec_ctrl_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op  (op_q),
    .a   (opa_q),
    .b   (opb_q),
    .imm (imm_q),
    .y   (alu_y)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (instr_valid) state_d = S_READ;
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state and latched fields only
  always_comb begin
    instr_ready     = (state_q == S_IDLE);
    done            = (state_q == S_WB);
    rf_write_enable = (state_q == S_WB) && op_writes(op_q);
  end

  always_comb begin
    op_d     = op_q;
    rd_d     = rd_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    imm_d    = imm_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    zero_d   = zero_q;
    if (state_q == S_IDLE && instr_valid) begin
      op_d  = instr_op;
      rd_d  = instr_rd;
      rs1_d = instr_rs1;
      rs2_d = instr_rs2;
      imm_d = instr_imm;
    end
    if (state_q == S_READ) begin
      opa_d = rf_read_data1;
      opb_d = rf_read_data2;
    end
    // NOP has no result to report, so the last one stays visible
    if (state_q == S_EXEC && op_writes(op_q)) begin
      result_d = alu_y;
      zero_d   = (alu_y == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      imm_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      op_q     <= op_d;
      rd_q     <= rd_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      imm_q    <= imm_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign rf_read_addr1 = rs1_q;
  assign rf_read_addr2 = rs2_q;
  assign rf_write_addr = rd_q;
  assign rf_write_data = result_q;
  assign result        = result_q;
  assign zero          = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_rf_exec_ctrl.sv
// ============================================================================
// Module : tb_rf_exec_ctrl
// Brief  : Self-checking bench for rf_exec_ctrl with a behavioural register file
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_rf_exec_ctrl;
  import rf_exec_ctrl_pkg::*;

  typedef struct {
    logic [2:0] op;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [7:0] imm;
    logic       we;
    logic [7:0] data;
  } vec_t;

  typedef struct {
    logic       we;
    logic [2:0] addr;
    logic [7:0] data;
    logic       chk_res;
    int         acc;
  } sb_t;

  logic       clk;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] instr_op;
  logic [2:0] instr_rd;
  logic [2:0] instr_rs1;
  logic [2:0] instr_rs2;
  logic [7:0] instr_imm;
  logic [2:0] rf_read_addr1;
  logic [2:0] rf_read_addr2;
  logic [7:0] rf_read_data1;
  logic [7:0] rf_read_data2;
  logic [2:0] rf_write_addr;
  logic [7:0] rf_write_data;
  logic       rf_write_enable;
  logic       done;
  logic [7:0] result;
  logic       zero;

  rf_exec_ctrl #(
    .DATA_W (8),
    .ADDR_W (3)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr_op        (instr_op),
    .instr_rd        (instr_rd),
    .instr_rs1       (instr_rs1),
    .instr_rs2       (instr_rs2),
    .instr_imm       (instr_imm),
    .rf_read_addr1   (rf_read_addr1),
    .rf_read_addr2   (rf_read_addr2),
    .rf_read_data1   (rf_read_data1),
    .rf_read_data2   (rf_read_data2),
    .rf_write_addr   (rf_write_addr),
    .rf_write_data   (rf_write_data),
    .rf_write_enable (rf_write_enable),
    .done            (done),
    .result          (result),
    .zero            (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] regs [0:7];
  assign rf_read_data1 = regs[rf_read_addr1];
  assign rf_read_data2 = regs[rf_read_addr2];
  always @(posedge clk) begin
    if (rf_write_enable) regs[rf_write_addr] <= rf_write_data;
  end

  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   accepts = 0;
  int   we_count = 0;
  bit   push_en = 1'b1;
  logic       drv_we = 1'b0;
  logic [7:0] drv_data = '0;
  logic       drv_chk = 1'b0;
  sb_t  sbq [$];
  sb_t  e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // Accept monitor: expected outcome is queued at the handshake edge
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rf_write_enable) we_count <= we_count + 1;
    if (!rst && instr_valid && instr_ready) begin
      accepts <= accepts + 1;
      if (push_en) sbq.push_back('{drv_we, instr_rd, drv_data, drv_chk, cyc});
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (sbq.size() == 0) begin
          fail_now("done_unexpected");
        end else begin
          e = sbq.pop_front();
          chk("done_latency", cyc, e.acc + 3);
          chk("wb_we", {31'd0, rf_write_enable}, {31'd0, e.we});
          if (e.we) begin
            chk("wb_addr", {29'd0, rf_write_addr}, {29'd0, e.addr});
            chk("wb_data", {24'd0, rf_write_data}, {24'd0, e.data});
          end
          if (e.chk_res) begin
            chk("result", {24'd0, result}, {24'd0, e.data});
            chk("zero", {31'd0, zero}, {31'd0, (e.data == 8'h00)});
          end
        end
      end else if (rf_write_enable) begin
        chk("we_without_done", 32'd1, 32'd0);
      end
    end
  end

  task automatic issue(input vec_t v, input bit scramble);
    int t;
    t = 0;
    @(negedge clk);
    while (!instr_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!instr_ready) fail_now("ready_timeout");
    instr_op    = v.op;
    instr_rd    = v.rd;
    instr_rs1   = v.rs1;
    instr_rs2   = v.rs2;
    instr_imm   = v.imm;
    drv_we      = v.we;
    drv_data    = v.data;
    drv_chk     = v.we;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    if (scramble) begin
      instr_op  = OP_LDI;
      instr_rd  = 3'd5;
      instr_rs1 = 3'd7;
      instr_rs2 = 3'd7;
      instr_imm = 8'h77;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
    end
    instr_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (sbq.size() != 0) begin
      fail_now("drain_timeout");
      sbq.delete();
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  vec_t vecs [11];
  vec_t pre  [3];
  vec_t tmp;
  int   we0;
  int   acc0;
  int   low;

  initial begin
    pre[0]  = '{OP_LDI, 3'd1, 3'd0, 3'd0, 8'h05, 1'b1, 8'h05};
    pre[1]  = '{OP_LDI, 3'd2, 3'd0, 3'd0, 8'h03, 1'b1, 8'h03};
    pre[2]  = '{OP_LDI, 3'd3, 3'd0, 3'd0, 8'hAA, 1'b1, 8'hAA};
    vecs[0]  = '{OP_LDI, 3'd1, 3'd0, 3'd0, 8'h05, 1'b1, 8'h05};
    vecs[1]  = '{OP_LDI, 3'd2, 3'd0, 3'd0, 8'h03, 1'b1, 8'h03};
    vecs[2]  = '{OP_ADD, 3'd3, 3'd1, 3'd2, 8'h00, 1'b1, 8'h08};
    vecs[3]  = '{OP_LDI, 3'd4, 3'd0, 3'd0, 8'hFF, 1'b1, 8'hFF};
    vecs[4]  = '{OP_LDI, 3'd5, 3'd0, 3'd0, 8'h02, 1'b1, 8'h02};
    vecs[5]  = '{OP_ADD, 3'd6, 3'd4, 3'd5, 8'h00, 1'b1, 8'h01};
    vecs[6]  = '{OP_SUB, 3'd7, 3'd5, 3'd4, 8'h00, 1'b1, 8'h03};
    vecs[7]  = '{OP_XOR, 3'd1, 3'd1, 3'd1, 8'h00, 1'b1, 8'h00};
    vecs[8]  = '{OP_MOV, 3'd2, 3'd1, 3'd0, 8'h00, 1'b1, 8'h00};
    vecs[9]  = '{OP_AND, 3'd0, 3'd4, 3'd6, 8'h00, 1'b1, 8'h01};
    vecs[10] = '{OP_OR,  3'd0, 3'd5, 3'd6, 8'h00, 1'b1, 8'h03};

    rst = 1'b1;
    instr_valid = 1'b0;
    instr_op = '0;
    instr_rd = '0;
    instr_rs1 = '0;
    instr_rs2 = '0;
    instr_imm = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_we", {31'd0, rf_write_enable}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", {24'd0, result}, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd1);
    chk("rst_raddr1", {29'd0, rf_read_addr1}, 32'd0);
    chk("rst_raddr2", {29'd0, rf_read_addr2}, 32'd0);
    chk("rst_waddr", {29'd0, rf_write_addr}, 32'd0);

    // Abort an ADD with reset asserted during its EXEC cycle
    for (int i = 0; i < 3; i++) issue(pre[i], 1'b0);
    drain();
    we0 = we_count;
    push_en = 1'b0;
    tmp = '{OP_ADD, 3'd3, 3'd1, 3'd2, 8'h00, 1'b1, 8'h08};
    issue(tmp, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_we", {31'd0, rf_write_enable}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    push_en = 1'b1;
    #1;
    chk("abort_ready", {31'd0, instr_ready}, 32'd1);
    chk("abort_result", {24'd0, result}, 32'd0);
    chk("abort_zero", {31'd0, zero}, 32'd1);
    repeat (6) @(negedge clk);
    chk("abort_no_strobe", we_count, we0);
    chk("abort_r3", {24'd0, regs[3]}, 32'hAA);

    for (int i = 0; i < 11; i++) issue(vecs[i], 1'b0);
    drain();
    chk("r1", {24'd0, regs[1]}, 32'h00);
    chk("r2", {24'd0, regs[2]}, 32'h00);
    chk("r3", {24'd0, regs[3]}, 32'h08);
    chk("r6", {24'd0, regs[6]}, 32'h01);
    chk("r7", {24'd0, regs[7]}, 32'h03);
    chk("r0", {24'd0, regs[0]}, 32'h03);

    // Inputs wiggled while busy must not disturb the latched ADD
    tmp = '{OP_ADD, 3'd0, 3'd5, 3'd5, 8'h00, 1'b1, 8'h04};
    issue(tmp, 1'b1);
    drain();
    chk("busy_r0", {24'd0, regs[0]}, 32'h04);
    chk("busy_r5", {24'd0, regs[5]}, 32'h02);

    // NOP stream with valid held high
    we0  = we_count;
    acc0 = accepts;
    low  = 0;
    @(negedge clk);
    instr_op    = OP_NOP;
    instr_rd    = 3'd6;
    drv_we      = 1'b0;
    drv_data    = 8'h00;
    drv_chk     = 1'b0;
    instr_valid = 1'b1;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      if (!instr_ready) low++;
    end
    instr_valid = 1'b0;
    drain();
    chk("nop_accepts", accepts - acc0, 32'd3);
    chk("nop_ready_low", low, 32'd9);
    chk("nop_no_strobe", we_count, we0);
    chk("nop_r6", {24'd0, regs[6]}, 32'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
